// File: rtl/prep_log_realign_pkg.sv
// Shared constants and FSM state type for the PREPARE payload realigner.
package prep_realign_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPass,
    StDrain
  } realign_state_e;

endpackage

// File: rtl/prep_log_realign_shifter.sv
// Byte-lane merge: upper lanes from held[offset..], lower lanes from src[0..offset-1].
// Byte 0 is the MSB lane, so a left shift moves later bytes toward lane 0.
module realign_shifter
  import prep_realign_pkg::*;
(
  input  logic [DATA_W-1:0] held_i,
  input  logic [DATA_W-1:0] src_i,
  input  logic [OFF_W-1:0]  offset_i,
  output logic [DATA_W-1:0] data_o
);

  localparam logic [OFF_W+3:0] WordBits = (OFF_W + 4)'(DATA_W);

  logic [OFF_W+2:0] held_sh;
  logic [OFF_W+3:0] src_sh;

  assign held_sh = {offset_i, 3'b000};
  // At offset 0 the src shift equals DATA_W, which clears every src lane.
  assign src_sh  = WordBits - {1'b0, held_sh};
  assign data_o  = (held_i << held_sh) | (src_i >> src_sh);

endmodule

// File: rtl/prep_log_realign.sv
// Re-packs the PREPARE log payload so log byte 0 lands in lane 0; drains trailing beats.
// Optional PREP_REALIGN_STATS_EN adds word/drain/truncation counters.
module prep_log_realign
  import prep_realign_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              realign_cmd_val,
  input  logic [OFF_W-1:0]  realign_cmd_offset,
  input  logic [LEN_W-1:0]  realign_cmd_len,
  output logic              realign_cmd_rdy,
  input  logic              src_realign_data_val,
  input  logic [DATA_W-1:0] src_realign_data,
  input  logic              src_realign_data_last,
  output logic              realign_src_data_rdy,
  output logic              realign_log_ctrl_rd_val,
  output logic [DATA_W-1:0] realign_log_ctrl_rd_data,
  output logic              realign_log_ctrl_rd_last,
  output logic [OFF_W-1:0]  realign_log_ctrl_rd_padbytes,
  input  logic              log_ctrl_realign_rd_rdy,
  output logic              realign_trunc_err
`ifdef PREP_REALIGN_STATS_EN
  ,
  output logic [31:0]       stat_words_out,
  output logic [31:0]       stat_beats_drained,
  output logic [15:0]       stat_trunc_cnt
`endif
);

  localparam logic [LEN_W-1:0] WordLen = LEN_W'(BYTES);

  realign_state_e    state_q, state_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] held_q, held_d;
  logic              held_last_q, held_last_d;

  logic [LEN_W-1:0]  held_bytes;
  logic              need_next;
  logic              rem_le_word;
  logic              trunc;
  logic              last_word;
  logic [OFF_W-1:0]  pad_word;
  logic              out_hs;

  assign held_bytes  = WordLen - LEN_W'(offset_q);
  assign need_next   = (rem_q > held_bytes) & ~held_last_q;
  assign rem_le_word = rem_q <= WordLen;
  // Input ended early: only the held word's bytes remain to be emitted.
  assign trunc       = held_last_q & (rem_q > held_bytes);
  assign last_word   = rem_le_word | trunc;
  assign pad_word    = trunc       ? offset_q :
                       rem_le_word ? OFF_W'(WordLen - rem_q) : '0;

  assign realign_cmd_rdy         = (state_q == StIdle);
  assign realign_log_ctrl_rd_val = (state_q == StPass) & (need_next ? src_realign_data_val : 1'b1);
  assign realign_src_data_rdy    = (state_q == StLoad) | (state_q == StDrain) |
                                   ((state_q == StPass) & need_next & log_ctrl_realign_rd_rdy);
  assign realign_log_ctrl_rd_last     = (state_q == StPass) & last_word;
  assign realign_log_ctrl_rd_padbytes = (state_q == StPass) ? pad_word : '0;

  assign out_hs            = realign_log_ctrl_rd_val & log_ctrl_realign_rd_rdy;
  assign realign_trunc_err = out_hs & trunc;

  realign_shifter u_shifter (
    .held_i   (held_q),
    .src_i    (src_realign_data),
    .offset_i (offset_q),
    .data_o   (realign_log_ctrl_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    rem_d       = rem_q;
    held_d      = held_q;
    held_last_d = held_last_q;
    unique case (state_q)
      StIdle: begin
        if (realign_cmd_val) begin
          offset_d = realign_cmd_offset;
          rem_d    = realign_cmd_len;
          state_d  = (realign_cmd_len == '0) ? StDrain : StLoad;
        end
      end
      StLoad: begin
        if (src_realign_data_val) begin
          held_d      = src_realign_data;
          held_last_d = src_realign_data_last;
          state_d     = StPass;
        end
      end
      StPass: begin
        if (out_hs) begin
          rem_d = rem_le_word ? '0 : rem_q - WordLen;
          if (need_next) begin
            held_d      = src_realign_data;
            held_last_d = src_realign_data_last;
          end
          if (last_word) begin
            state_d = (held_last_q || (need_next && src_realign_data_last)) ? StIdle : StDrain;
          end
        end
      end
      StDrain: begin
        if (src_realign_data_val && src_realign_data_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      offset_q    <= '0;
      rem_q       <= '0;
      held_q      <= '0;
      held_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      rem_q       <= rem_d;
      held_q      <= held_d;
      held_last_q <= held_last_d;
    end
  end

`ifdef PREP_REALIGN_STATS_EN
  logic [31:0] words_q;
  logic [31:0] drained_q;
  logic [15:0] trunc_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q     <= '0;
      drained_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      if (out_hs) words_q <= words_q + 32'd1;
      if ((state_q == StDrain) && src_realign_data_val) drained_q <= drained_q + 32'd1;
      if (realign_trunc_err) trunc_cnt_q <= trunc_cnt_q + 16'd1;
    end
  end

  assign stat_words_out     = words_q;
  assign stat_beats_drained = drained_q;
  assign stat_trunc_cnt     = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_prep_log_realign.sv
// Scoreboard bench for prep_log_realign: expected aligned words queued from a byte-stream model.
module tb_prep_log_realign;
  import prep_realign_pkg::*;

  logic              clk;
  logic              rst;
  logic              cmd_val;
  logic [OFF_W-1:0]  cmd_offset;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_rdy;
  logic              src_val;
  logic [DATA_W-1:0] src_data;
  logic              src_last;
  logic              src_rdy;
  logic              rd_val;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic [OFF_W-1:0]  rd_pad;
  logic              dst_rdy;
  logic              trunc_err;
`ifdef PREP_REALIGN_STATS_EN
  logic [31:0]       st_words;
  logic [31:0]       st_drained;
  logic [15:0]       st_trunc;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    int                nvalid;
    logic              last;
    logic [OFF_W-1:0]  pad;
    logic              trunc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  prep_log_realign dut (
    .clk                          (clk),
    .rst                          (rst),
    .realign_cmd_val              (cmd_val),
    .realign_cmd_offset           (cmd_offset),
    .realign_cmd_len              (cmd_len),
    .realign_cmd_rdy              (cmd_rdy),
    .src_realign_data_val         (src_val),
    .src_realign_data             (src_data),
    .src_realign_data_last        (src_last),
    .realign_src_data_rdy         (src_rdy),
    .realign_log_ctrl_rd_val      (rd_val),
    .realign_log_ctrl_rd_data     (rd_data),
    .realign_log_ctrl_rd_last     (rd_last),
    .realign_log_ctrl_rd_padbytes (rd_pad),
    .log_ctrl_realign_rd_rdy      (dst_rdy),
    .realign_trunc_err            (trunc_err)
`ifdef PREP_REALIGN_STATS_EN
    ,
    .stat_words_out               (st_words),
    .stat_beats_drained           (st_drained),
    .stat_trunc_cnt               (st_trunc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; cmd_val = 1'b0; cmd_offset = '0; cmd_len = '0;
    src_val = 1'b0; src_data = '0; src_last = 1'b0; dst_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy got=%b want=1", cmd_rdy); end
    checks++; if (src_rdy !== 1'b0) begin errors++; $display("FAIL reset_src_rdy got=%b want=0", src_rdy); end
    checks++; if (rd_val !== 1'b0) begin errors++; $display("FAIL reset_rd_val got=%b want=0", rd_val); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got=%b want=0", rd_last); end
    checks++; if (rd_pad !== '0) begin errors++; $display("FAIL reset_padbytes got=%0d want=0", rd_pad); end
    checks++; if (trunc_err !== 1'b0) begin errors++; $display("FAIL reset_trunc got=%b want=0", trunc_err); end
  endtask

  // Drives one descriptor plus nin input words; last flag on the final word.
  task automatic run_packet(input string name, input int off, input int len, input int nin,
                            input bit stall, input int exp_drain);
    logic [7:0]        bytes [0:511];
    logic [DATA_W-1:0] words [0:7];
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    logic [OFF_W-1:0]  prev_pad;
    exp_t              e;
    int                avail, valid, nout, sidx, drained, cyc, qn;
    bit                cmd_sent, prev_stall, bad;

    for (int w = 0; w < nin; w++) begin
      words[w] = '0;
      for (int b = 0; b < BYTES; b++) begin
        bytes[w*BYTES + b] = 8'($urandom);
        words[w][DATA_W-1-8*b -: 8] = bytes[w*BYTES + b];
      end
    end
    avail = nin * BYTES - off;
    valid = (len < avail) ? len : avail;
    nout  = (valid + BYTES - 1) / BYTES;
    for (int i = 0; i < nout; i++) begin
      e.data   = '0;
      e.nvalid = valid - i * BYTES;
      if (e.nvalid > BYTES) e.nvalid = BYTES;
      for (int k = 0; k < e.nvalid; k++) e.data[DATA_W-1-8*k -: 8] = bytes[off + i*BYTES + k];
      e.last  = (i == nout - 1);
      e.pad   = e.last ? OFF_W'(nout * BYTES - valid) : '0;
      e.trunc = e.last && (len > avail);
      exp_q.push_back(e);
    end

    sidx = 0; drained = 0; cyc = 0; cmd_sent = 0; prev_stall = 0;
    prev_data = '0; prev_last = 1'b0; prev_pad = '0;
    while (!(cmd_sent && sidx == nin && exp_q.size() == 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      qn         = exp_q.size();
      cmd_val    = !cmd_sent;
      cmd_offset = OFF_W'(off);
      cmd_len    = LEN_W'(len);
      src_val    = (sidx < nin) && (!stall || $urandom_range(0, 3) != 0);
      if (sidx < nin) begin
        src_data = words[sidx];
        src_last = (sidx == nin - 1);
      end
      dst_rdy = !stall || ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall && rd_val) begin
        checks++;
        if (rd_data !== prev_data || rd_last !== prev_last || rd_pad !== prev_pad) begin
          errors++;
          $display("FAIL %s stall_stable last=%b/%b pad=%0d/%0d", name, rd_last, prev_last,
                   rd_pad, prev_pad);
        end
      end
      if (rd_val && dst_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_word got data=%h want none", name, rd_data);
        end else begin
          e = exp_q.pop_front();
          bad = 0;
          for (int k = 0; k < e.nvalid; k++)
            if (rd_data[DATA_W-1-8*k -: 8] !== e.data[DATA_W-1-8*k -: 8]) bad = 1;
          if (bad) begin
            errors++;
            $display("FAIL %s data got=%h want=%h", name, rd_data, e.data);
          end
          checks++;
          if (rd_last !== e.last) begin
            errors++; $display("FAIL %s last got=%b want=%b", name, rd_last, e.last);
          end
          checks++;
          if (e.last && rd_pad !== e.pad) begin
            errors++; $display("FAIL %s padbytes got=%0d want=%0d", name, rd_pad, e.pad);
          end
          checks++;
          if (trunc_err !== e.trunc) begin
            errors++; $display("FAIL %s trunc_err got=%b want=%b", name, trunc_err, e.trunc);
          end
        end
      end else begin
        checks++;
        if (trunc_err !== 1'b0) begin
          errors++; $display("FAIL %s trunc_idle got=%b want=0", name, trunc_err);
        end
      end
      prev_stall = rd_val && !dst_rdy;
      prev_data  = rd_data;
      prev_last  = rd_last;
      prev_pad   = rd_pad;
      if (cmd_val && cmd_rdy) cmd_sent = 1;
      if (src_val && src_rdy) begin
        if (qn == 0) drained++;
        sidx++;
      end
    end

    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL %s timeout words_left=%0d beats_read=%0d want=%0d", name, exp_q.size(),
               sidx, nin);
      exp_q.delete();
    end
    @(negedge clk);
    cmd_val = 1'b0; src_val = 1'b0; dst_rdy = 1'b1;
    #1;
    checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL %s end_cmd_rdy got=%b want=1", name, cmd_rdy); end
    checks++;
    if (src_rdy !== 1'b0) begin errors++; $display("FAIL %s end_src_rdy got=%b want=0", name, src_rdy); end
    checks++;
    if (drained !== exp_drain) begin
      errors++; $display("FAIL %s drained got=%0d want=%0d", name, drained, exp_drain);
    end
  endtask

  task automatic test_aligned();    run_packet("aligned", 0, 128, 2, 0, 0);  endtask
  task automatic test_offset();     run_packet("offset", 10, 100, 2, 0, 0);  endtask
  task automatic test_drain();      run_packet("drain", 10, 20, 3, 0, 2);    endtask
  task automatic test_stall();      run_packet("stall", 37, 300, 6, 1, 0);   endtask
  task automatic test_trunc();      run_packet("trunc", 0, 200, 2, 0, 0);    endtask

  task automatic test_back_to_back();
    run_packet("max_offset", 63, 64, 2, 1, 0);
    run_packet("one_byte", 0, 1, 1, 0, 0);
    run_packet("trunc_off", 10, 200, 2, 1, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_val = 1'b1; cmd_offset = OFF_W'(37); cmd_len = LEN_W'(300);
    src_val = 1'b0; dst_rdy = 1'b0;
    @(negedge clk);
    cmd_val = 1'b0; src_val = 1'b1; src_data = {16{$urandom}}; src_last = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (rd_val !== 1'b1) begin errors++; $display("FAIL mid_pass_val got=%b want=1", rd_val); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; src_val = 1'b1; dst_rdy = 1'b1;
    #1;
    checks++; if (rd_val !== 1'b0) begin errors++; $display("FAIL midrst_rd_val got=%b want=0", rd_val); end
    checks++; if (src_rdy !== 1'b0) begin errors++; $display("FAIL midrst_src_rdy got=%b want=0", src_rdy); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL midrst_cmd_rdy got=%b want=1", cmd_rdy); end
    @(negedge clk);
    src_val = 1'b0;
    run_packet("after_rst", 5, 70, 2, 0, 0);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset();
    test_drain();
    test_stall();
    test_trunc();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
